seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 18 +
 rtl/hex_to_seg7.sv | 12 +
 rtl/seg7_scan_driver.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared widths and the hex-to-segment table
// for the multiplexed 7-segment display driver.
package seg7_pkg;

  localparam int SEG_W    = 7;
  localparam int NIBBLE_W = 4;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Entry n is the {A..G} pattern for hex digit n.
  localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,
    7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33,
    7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational nibble to logical
// (1 = lit) segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, time-multiplexed
// N-digit 7-segment scanner with blanking and blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int PRESCALE       = 1000,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [NIBBLE_W*N_DIGITS-1:0] load_data,
  input  logic                         blank_lz,
  input  logic                         blink_en,
  output logic [SEG_W-1:0]             seg,
  output logic [N_DIGITS-1:0]          an,
  output logic                         frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW =
    (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = NIBBLE_W * N_DIGITS;

  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  localparam logic [SEG_W-1:0] SEG_INV =
    (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [N_DIGITS-1:0] AN_INV =
    (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}}
                         : {N_DIGITS{1'b0}};

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       fcnt;
  logic                phase;
  logic [DW-1:0]       active;
  logic [DW-1:0]       pend_val;
  logic                pending;
  logic [SEG_W-1:0]    seg_q;
  logic [N_DIGITS-1:0] an_q;

  logic                tick;
  logic                boundary;
  logic                accept;
  logic [NIBBLE_W-1:0] nib;
  logic [SEG_W-1:0]    dec_seg;
  logic                lz_zero;
  logic                blank;
  logic [SEG_W-1:0]    seg_l;
  logic [N_DIGITS-1:0] an_l;

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (idx == IDX_MAX);

  assign load_ready = ~pending & ~rst;
  assign accept     = load_valid & load_ready;
  assign frame_done = boundary & ~rst;

  assign nib = active[idx*NIBBLE_W +: NIBBLE_W];

  // Digit idx and everything above it are zero.
  assign lz_zero =
    ((active >> (idx * NIBBLE_W)) == '0);
  assign blank = blank_lz && (idx != '0) && lz_zero;

  hex_to_seg7 u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_l = blank ? SEG_OFF : dec_seg;
    an_l  = '0;
    // Anode stays off on the slot's first cycle.
    for (int i = 0; i < N_DIGITS; i++) begin
      an_l[i] = (cnt != '0) && (idx == IW'(i));
    end
    if (blink_en && phase) begin
      seg_l = SEG_OFF;
      an_l  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      fcnt     <= '0;
      phase    <= 1'b0;
      active   <= '0;
      pend_val <= '0;
      pending  <= 1'b0;
      seg_q    <= SEG_OFF ^ SEG_INV;
      an_q     <= AN_INV;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
      if (accept) begin
        pend_val <= load_data;
        pending  <= 1'b1;
      end else if (boundary && pending) begin
        active  <= pend_val;
        pending <= 1'b0;
      end
      if (boundary) begin
        if (fcnt == FRM_MAX) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
      seg_q <= seg_l ^ SEG_INV;
      an_q  <= an_l ^ AN_INV;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
